// File: rtl/memory_responder_if.sv
// Memory port bundle between the processor (master) and the responder (slave).
//   req_valid/req_ready  request handshake, accept when both high on posedge
//   req_mode             2'b01 read, 2'b10 write, others reserved
//   req_addr             16-bit word address
//   req_wdata            write data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           read data or echoed write data, held between responses
//   resp_err             access error flag (only meaningful with MEMRESP_ERR_EN)
//   busy                 request in flight
interface memory_responder_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [15:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             busy;

  modport master (
    output req_valid, req_mode, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_mode, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/memory_responder.sv
// Handshaked memory responder with fixed access latency.
// Accepts one request per handshake, counts LATENCY cycles, performs the
// read/write on an internal word array and pulses resp_valid for one cycle.
// Ports:
//   clk    system clock (posedge)
//   reset  asynchronous active-high reset
//   bus    memory_responder_if.slave (request/response signals)
// Optional feature: define MEMRESP_ERR_EN to flag out-of-range addresses
// and reserved modes on resp_err instead of wrapping / silently completing.
module memory_responder #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  memory_responder_if.slave   bus
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [1:0]             mode_q;
  logic [15:0]            addr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [WIDTH-1:0]       rdata_q;
  logic                   err_q;
  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   accept, done;
  logic                   is_rd, is_wr, acc_err;
  logic [ADDR_BITS-1:0]   idx;

  assign bus.req_ready  = (state != WAIT);
  assign bus.busy       = (state == WAIT);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;
  // Completing edge: last WAIT cycle, counter exhausted.
  assign done   = (state == WAIT) && (cnt == 4'd0);

  assign is_rd  = (mode_q == 2'b01);
  assign is_wr  = (mode_q == 2'b10);
  assign idx    = addr_q[ADDR_BITS-1:0];

`ifdef MEMRESP_ERR_EN
  assign acc_err = (|addr_q[15:ADDR_BITS]) || !(is_rd || is_wr);
`else
  // Upper address bits wrap; they are deliberately not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[15:ADDR_BITS];
  assign acc_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = accept ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      mode_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= bus.req_mode;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        if (acc_err)    rdata_q <= '0;
        else if (is_rd) rdata_q <= mem[idx];
        else if (is_wr) rdata_q <= wdata_q;
        else            rdata_q <= '0;
        err_q <= acc_err;
      end
    end
  end

  // Array is not reset. The reset guard keeps an abandoned op from writing
  // when reset and the completing edge coincide.
  always_ff @(posedge clk) begin
    if (!reset && done && is_wr && !acc_err) mem[idx] <= wdata_q;
  end
endmodule
